// File: rtl/decode_register_file.sv
// ---------------------------------------------------------------------------
// decode_register_file
//
// Register file and stack-pointer unit for the decode stage. Holds eight
// general-purpose registers and the stack pointer, and supplies the source,
// destination and SP values that the decode/execute pipeline register
// captures on the next rising edge.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   en                 decode advance; 0 stalls SP updates only
//   reg_src_1_num      source-1 register number (always a valid register)
//   reg_src_2_num      source-2 register number, 8..15 = none (reads 0)
//   reg_dst_num        destination register number, 8..15 = none (reads 0)
//   sp_op, sp_amount   00/11 none, 01 push, 10 pop; step of 1 or 2 words
//   wb1_*              write-back port 1 (wins on same-register conflict)
//   wb2_*              write-back port 2 (second result of SWAP)
//   reg_src_1_value    source-1 value (write-through bypassed)
//   reg_src_2_value    source-2 value (write-through bypassed)
//   reg_dst_value      destination register's current value (bypassed)
//   SP_value           memory address for this instruction's stack access
// ---------------------------------------------------------------------------
module decode_register_file #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    NUM_REGS   = 8,
   parameter int                    SP_WIDTH   = 32,
   parameter logic [SP_WIDTH-1:0]   SP_RESET   = 'h000F_FFFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [2:0]            reg_src_1_num,
   input  logic [3:0]            reg_src_2_num,
   input  logic [3:0]            reg_dst_num,
   input  logic [1:0]            sp_op,
   input  logic                  sp_amount,
   input  logic                  wb1_en,
   input  logic [3:0]            wb1_num,
   input  logic [DATA_WIDTH-1:0] wb1_value,
   input  logic                  wb2_en,
   input  logic [3:0]            wb2_num,
   input  logic [DATA_WIDTH-1:0] wb2_value,
   output logic [DATA_WIDTH-1:0] reg_src_1_value,
   output logic [DATA_WIDTH-1:0] reg_src_2_value,
   output logic [DATA_WIDTH-1:0] reg_dst_value,
   output logic [SP_WIDTH-1:0]   SP_value
);

   localparam int         IDX_W = $clog2(NUM_REGS);
   localparam logic [4:0] NREG  = 5'(NUM_REGS);

   localparam logic [1:0] SP_OP_PUSH = 2'b01;
   localparam logic [1:0] SP_OP_POP  = 2'b10;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [SP_WIDTH-1:0]   sp_q;
   logic [SP_WIDTH-1:0]   sp_d;

   logic                  wb1_valid;
   logic                  wb2_valid;
   logic [SP_WIDTH-1:0]   sp_step;
   logic [SP_WIDTH-1:0]   sp_plus;
   logic [SP_WIDTH-1:0]   sp_minus;

   assign wb1_valid = wb1_en && ({1'b0, wb1_num} < NREG);
   assign wb2_valid = wb2_en && ({1'b0, wb2_num} < NREG);

   // Read with write-through bypass: a write presented this cycle is visible
   // before the edge that stores it. Port 1 is checked first so the bypass
   // agrees with the value that will actually be stored on a conflict.
   function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [3:0] num);
      if ({1'b0, num} >= NREG)
         return '0;
      else if (wb1_en && (wb1_num == num))
         return wb1_value;
      else if (wb2_en && (wb2_num == num))
         return wb2_value;
      else
         return regs_q[num[IDX_W-1:0]];
   endfunction

   assign reg_src_1_value = read_reg({1'b0, reg_src_1_num});
   assign reg_src_2_value = read_reg(reg_src_2_num);
   assign reg_dst_value   = read_reg(reg_dst_num);

   // Stack pointer arithmetic wraps modulo 2^SP_WIDTH by construction.
   assign sp_step  = sp_amount ? SP_WIDTH'(2) : SP_WIDTH'(1);
   assign sp_plus  = sp_q + sp_step;
   assign sp_minus = sp_q - sp_step;

   // A pop addresses the slot above SP; push and none address SP itself.
   // This stays valid while stalled so the held instruction sees a stable
   // address.
   assign SP_value = (sp_op == SP_OP_POP) ? sp_plus : sp_q;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path
      // through this block leaves a value unassigned and no latch is inferred.
      regs_d = regs_q;
      sp_d   = sp_q;

      // Port 2 first, then port 1, so port 1 overwrites on a conflict.
      // Write-back is independent of en: writes complete during stalls.
      if (wb2_valid) regs_d[wb2_num[IDX_W-1:0]] = wb2_value;
      if (wb1_valid) regs_d[wb1_num[IDX_W-1:0]] = wb1_value;

      if (en) begin
         case (sp_op)
            SP_OP_PUSH: sp_d = sp_minus;
            SP_OP_POP:  sp_d = sp_plus;
            default:    sp_d = sp_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      if (reset) begin
         // NOTE: the register array is reset explicitly because software
         // relies on R0..R7 reading zero after reset; this keeps it as
         // flops rather than a RAM macro, which is fine at eight entries.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         sp_q <= SP_RESET;
      end else begin
         regs_q <= regs_d;
         sp_q   <= sp_d;
      end
   end

endmodule

// File: tb/tb_decode_register_file.sv
// ---------------------------------------------------------------------------
// tb_decode_register_file
//
// Self-checking bench for decode_register_file. A second instance with
// SP_RESET = 0 shares all inputs and is used for the stack wrap-around case.
// ---------------------------------------------------------------------------
module tb_decode_register_file;

   logic        clk;
   logic        reset;
   logic        en;
   logic [2:0]  reg_src_1_num;
   logic [3:0]  reg_src_2_num;
   logic [3:0]  reg_dst_num;
   logic [1:0]  sp_op;
   logic        sp_amount;
   logic        wb1_en;
   logic [3:0]  wb1_num;
   logic [15:0] wb1_value;
   logic        wb2_en;
   logic [3:0]  wb2_num;
   logic [15:0] wb2_value;

   logic [15:0] src1_a, src2_a, dst_a;
   logic [31:0] sp_a;
   logic [15:0] src1_z, src2_z, dst_z;
   logic [31:0] sp_z;

   int n_vec = 0;
   int n_bad = 0;

   decode_register_file u_dut (
      .clk(clk), .reset(reset), .en(en),
      .reg_src_1_num(reg_src_1_num), .reg_src_2_num(reg_src_2_num),
      .reg_dst_num(reg_dst_num), .sp_op(sp_op), .sp_amount(sp_amount),
      .wb1_en(wb1_en), .wb1_num(wb1_num), .wb1_value(wb1_value),
      .wb2_en(wb2_en), .wb2_num(wb2_num), .wb2_value(wb2_value),
      .reg_src_1_value(src1_a), .reg_src_2_value(src2_a),
      .reg_dst_value(dst_a), .SP_value(sp_a)
   );

   decode_register_file #(.SP_RESET(32'h0000_0000)) u_dut_z (
      .clk(clk), .reset(reset), .en(en),
      .reg_src_1_num(reg_src_1_num), .reg_src_2_num(reg_src_2_num),
      .reg_dst_num(reg_dst_num), .sp_op(sp_op), .sp_amount(sp_amount),
      .wb1_en(wb1_en), .wb1_num(wb1_num), .wb1_value(wb1_value),
      .wb2_en(wb2_en), .wb2_num(wb2_num), .wb2_value(wb2_value),
      .reg_src_1_value(src1_z), .reg_src_2_value(src2_z),
      .reg_dst_value(dst_z), .SP_value(sp_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned m_regs [8];
   int unsigned m_sp;
   int unsigned m_sp_z;

   function automatic int unsigned step_words();
      return (sp_amount == 1'b1) ? 2 : 1;
   endfunction

   // Value a read of register 'num' must return right now.
   function automatic int unsigned exp_read(input int unsigned num);
      if (num >= 8) return 0;
      if (wb1_en && wb1_num == num) return wb1_value;
      if (wb2_en && wb2_num == num) return wb2_value;
      return m_regs[num];
   endfunction

   function automatic int unsigned exp_sp_value(input int unsigned sp);
      if (sp_op == 2'b10) return sp + step_words();
      return sp;
   endfunction

   // Apply the architectural effect of the current inputs at a clock edge.
   function automatic void model_edge();
      if (reset) begin
         foreach (m_regs[i]) m_regs[i] = 0;
         m_sp   = 32'h000F_FFFF;
         m_sp_z = 0;
      end else begin
         if (wb2_en && wb2_num < 8) m_regs[wb2_num] = wb2_value;
         if (wb1_en && wb1_num < 8) m_regs[wb1_num] = wb1_value;
         if (en && sp_op == 2'b01) begin
            m_sp   = m_sp - step_words();
            m_sp_z = m_sp_z - step_words();
         end else if (en && sp_op == 2'b10) begin
            m_sp   = m_sp + step_words();
            m_sp_z = m_sp_z + step_words();
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " src1"}, {16'h0, src1_a}, exp_read(reg_src_1_num));
      check({tag, " src2"}, {16'h0, src2_a}, exp_read(reg_src_2_num));
      check({tag, " dst"},  {16'h0, dst_a},  exp_read(reg_dst_num));
      check({tag, " sp"},   sp_a,            exp_sp_value(m_sp));
      check({tag, " sp_z"}, sp_z,            exp_sp_value(m_sp_z));
      check({tag, " z_src2"}, {16'h0, src2_z}, exp_read(reg_src_2_num));
      check({tag, " z_dst"},  {16'h0, dst_z},  exp_read(reg_dst_num));
      check({tag, " z_src1"}, {16'h0, src1_z}, exp_read(reg_src_1_num));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        chk;
      logic        rst;
      logic        en;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  dst;
      logic [1:0]  op;
      logic        amt;
      logic        w1e;
      logic [3:0]  w1n;
      logic [15:0] w1v;
      logic        w2e;
      logic [3:0]  w2n;
      logic [15:0] w2v;
      logic [15:0] e1;
      logic [15:0] e2;
      logic [15:0] ed;
      logic [31:0] esp;
   } vec_t;

   vec_t tbl [18];

   task automatic drive(input vec_t v);
      reset = v.rst;  en = v.en;
      reg_src_1_num = v.s1;  reg_src_2_num = v.s2;  reg_dst_num = v.dst;
      sp_op = v.op;  sp_amount = v.amt;
      wb1_en = v.w1e;  wb1_num = v.w1n;  wb1_value = v.w1v;
      wb2_en = v.w2e;  wb2_num = v.w2n;  wb2_value = v.w2v;
   endtask

   task automatic idle_inputs();
      reset = 0; en = 1; reg_src_1_num = 0; reg_src_2_num = 0; reg_dst_num = 0;
      sp_op = 0; sp_amount = 0; wb1_en = 0; wb1_num = 0; wb1_value = 0;
      wb2_en = 0; wb2_num = 0; wb2_value = 0;
   endtask

   initial begin
      //            chk rst en s1 s2  dst op amt w1e w1n w1v       w2e w2n w2v       e1        e2        ed        esp
      tbl[0]  = '{1'b0,1'b1,1'b1,3'd2,4'd2, 4'd2,2'd0,1'b0,1'b1,4'd2, 16'hAAAA,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h0};
      tbl[1]  = '{1'b1,1'b0,1'b1,3'd2,4'd2, 4'd2,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[2]  = '{1'b1,1'b0,1'b1,3'd3,4'd15,4'd15,2'd0,1'b0,1'b1,4'd3,16'h1234,1'b0,4'd0, 16'h0000,16'h1234,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[3]  = '{1'b1,1'b0,1'b1,3'd3,4'd3, 4'd3,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h1234,16'h1234,16'h1234,32'h000F_FFFF};
      tbl[4]  = '{1'b1,1'b0,1'b1,3'd5,4'd5, 4'd4,2'd0,1'b0,1'b1,4'd5, 16'h1111,1'b1,4'd5, 16'h2222,16'h1111,16'h1111,16'h0000,32'h000F_FFFF};
      tbl[5]  = '{1'b1,1'b0,1'b1,3'd5,4'd1, 4'd6,2'd0,1'b0,1'b1,4'd1, 16'h00FF,1'b1,4'd6, 16'hFF00,16'h1111,16'h00FF,16'hFF00,32'h000F_FFFF};
      tbl[6]  = '{1'b1,1'b0,1'b1,3'd1,4'd6, 4'd5,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h00FF,16'hFF00,16'h1111,32'h000F_FFFF};
      tbl[7]  = '{1'b1,1'b0,1'b1,3'd0,4'd15,4'd3,2'd0,1'b0,1'b1,4'd15,16'hDEAD,1'b1,4'd9, 16'hBEEF,16'h0000,16'h0000,16'h1234,32'h000F_FFFF};
      tbl[8]  = '{1'b1,1'b0,1'b1,3'd7,4'd0, 4'd1,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h00FF,32'h000F_FFFF};
      // Push step 2 from the reset SP, then a stalled pop, then release.
      tbl[9]  = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd1,1'b1,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[10] = '{1'b1,1'b0,1'b0,3'd4,4'd0, 4'd0,2'd2,1'b1,1'b1,4'd4, 16'h4444,1'b0,4'd0, 16'h0000,16'h4444,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[11] = '{1'b1,1'b0,1'b0,3'd4,4'd0, 4'd0,2'd2,1'b1,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h4444,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[12] = '{1'b1,1'b0,1'b0,3'd0,4'd0, 4'd0,2'd2,1'b1,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[13] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd2,1'b1,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[14] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      // sp_op = 11 behaves as none.
      tbl[15] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd3,1'b1,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      tbl[16] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd0,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};
      // Push step 1 then read: SP now one below reset value.
      tbl[17] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 4'd0,2'd1,1'b0,1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,32'h000F_FFFF};

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i]);
         #2;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d src1", i), {16'h0, src1_a}, {16'h0, tbl[i].e1});
            check($sformatf("vec%0d src2", i), {16'h0, src2_a}, {16'h0, tbl[i].e2});
            check($sformatf("vec%0d dst", i),  {16'h0, dst_a},  {16'h0, tbl[i].ed});
            check($sformatf("vec%0d sp", i),   sp_a,            tbl[i].esp);
         end
         tick();
      end
      idle_inputs();
      #1;
      check("after push1 sp", sp_a, 32'h000F_FFFE);

      // ---------------- reset dominance and wrap-around ----------------
      reset = 1; en = 1; sp_op = 2'b01; sp_amount = 1;
      wb1_en = 1; wb1_num = 4'd2; wb1_value = 16'hAAAA;
      wb2_en = 1; wb2_num = 4'd3; wb2_value = 16'h5555;
      tick();
      idle_inputs();
      reg_src_1_num = 3'd2; reg_src_2_num = 4'd3; reg_dst_num = 4'd5;
      #1;
      check("reset r2",   {16'h0, src1_a}, 32'h0);
      check("reset r3",   {16'h0, src2_a}, 32'h0);
      check("reset r5",   {16'h0, dst_a},  32'h0);
      check("reset sp",   sp_a, 32'h000F_FFFF);
      check("reset sp_z", sp_z, 32'h0);

      sp_op = 2'b01; sp_amount = 0; #1;
      check("wrap push addr", sp_z, 32'h0);
      tick();
      sp_op = 2'b00; #1;
      check("wrap after push", sp_z, 32'hFFFF_FFFF);
      check("push1 main", sp_a, 32'h000F_FFFE);
      sp_op = 2'b10; sp_amount = 1; #1;
      check("wrap pop addr", sp_z, 32'h0000_0001);
      tick();
      sp_op = 2'b00; #1;
      check("wrap after pop", sp_z, 32'h0000_0001);

      // ---------------- randomized against the model ----------------
      for (int c = 0; c < 400; c++) begin
         reset         = ($urandom_range(0, 49) == 0);
         en            = ($urandom_range(0, 3) != 0);
         reg_src_1_num = 3'($urandom);
         reg_src_2_num = 4'($urandom);
         reg_dst_num   = 4'($urandom);
         sp_op         = 2'($urandom);
         sp_amount     = 1'($urandom);
         wb1_en        = 1'($urandom);
         wb1_num       = 4'($urandom);
         wb1_value     = 16'($urandom);
         wb2_en        = 1'($urandom);
         wb2_num       = ($urandom_range(0, 3) == 0) ? wb1_num : 4'($urandom);
         wb2_value     = 16'($urandom);
         #2;
         check_model($sformatf("rnd%0d", c));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
